// File: rtl/nanomamba_vad_wake.sv
// Always-on energy VAD: per-frame energy, adaptive noise floor, onset/hangover FSM
// and a level wake request for the power manager.
`timescale 1ns/1ps
module nanomamba_vad_wake #(
  parameter int unsigned     SAMPLE_W     = 16,
  parameter int unsigned     FRAME_LEN    = 160,
  parameter int unsigned     ENERGY_W     = 40,
  parameter int unsigned     ONSET_FRAMES = 3,
  parameter int unsigned     HANG_FRAMES  = 30,
  parameter int unsigned     NF_SHIFT     = 4,
  parameter int unsigned     THRESH_SHIFT = 2,
  parameter longint unsigned MIN_FLOOR    = 65536
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_data,
  input  logic                       wake_ack,
  output logic                       vad_trigger,
  output logic                       wake_req,
  output logic                       speech_active,
  output logic                       frame_strobe,
  output logic [ENERGY_W-1:0]        frame_energy,
  output logic [ENERGY_W-1:0]        noise_floor,
  output logic [2:0]                 vad_state
);

  localparam int unsigned PROD_W = 2 * SAMPLE_W;
  localparam int unsigned CNT_W  = $clog2(FRAME_LEN);
  localparam int unsigned ON_W   = $clog2(ONSET_FRAMES + 1);
  localparam int unsigned HANG_W = $clog2(HANG_FRAMES + 1);
  localparam int unsigned CMP_W  = ENERGY_W + THRESH_SHIFT;
  localparam int unsigned NF_W   = ENERGY_W + 1;
  localparam logic [ENERGY_W-1:0] MIN_FLOOR_E = ENERGY_W'(MIN_FLOOR);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALIB   = 3'd1,
    ST_SILENCE = 3'd2,
    ST_ONSET   = 3'd3,
    ST_SPEECH  = 3'd4,
    ST_HANG    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ENERGY_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ON_W-1:0]     onset_q, onset_d;
  logic [HANG_W-1:0]   hang_q, hang_d;
  logic [ENERGY_W-1:0] frame_energy_q, frame_energy_d;
  logic                frame_strobe_q, frame_strobe_d;
  logic [ENERGY_W-1:0] nf_q, nf_d;
  logic                trig_q, trig_d;
  logic                wake_q, wake_d;
  logic                speech_q, speech_d;

  logic signed [PROD_W-1:0] samp_ext;
  logic signed [PROD_W-1:0] prod;
  logic [ENERGY_W-1:0]      acc_sum;
  logic                     frame_last;
  logic [CMP_W-1:0]         thresh;
  logic                     loud;
  logic signed [NF_W-1:0]   nf_diff, nf_step, nf_sum;
  logic [ENERGY_W-1:0]      nf_upd, nf_calib;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      onset_q        <= '0;
      hang_q         <= '0;
      frame_energy_q <= '0;
      frame_strobe_q <= 1'b0;
      nf_q           <= MIN_FLOOR_E;
      trig_q         <= 1'b0;
      wake_q         <= 1'b0;
      speech_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      onset_q        <= onset_d;
      hang_q         <= hang_d;
      frame_energy_q <= frame_energy_d;
      frame_strobe_q <= frame_strobe_d;
      nf_q           <= nf_d;
      trig_q         <= trig_d;
      wake_q         <= wake_d;
      speech_q       <= speech_d;
    end
  end

  // Frame energy accumulation; a disabled detector discards the partial frame
  always_comb begin
    samp_ext       = PROD_W'(sample_data);
    prod           = samp_ext * samp_ext;
    acc_sum        = acc_q + ENERGY_W'($unsigned(prod));
    frame_last     = (cnt_q == CNT_W'(FRAME_LEN - 1));
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    frame_energy_d = frame_energy_q;
    frame_strobe_d = 1'b0;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_valid) begin
      if (frame_last) begin
        frame_energy_d = acc_sum;
        acc_d          = '0;
        cnt_d          = '0;
        frame_strobe_d = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Loudness decision and noise-floor candidates for the frame just completed
  always_comb begin
    thresh   = CMP_W'(nf_q) << THRESH_SHIFT;
    loud     = (CMP_W'(frame_energy_q) > thresh);
    nf_diff  = $signed({1'b0, frame_energy_q}) - $signed({1'b0, nf_q});
    nf_step  = nf_diff >>> NF_SHIFT;
    nf_sum   = $signed({1'b0, nf_q}) + nf_step;
    nf_upd   = (nf_sum < $signed({1'b0, MIN_FLOOR_E})) ? MIN_FLOOR_E : nf_sum[ENERGY_W-1:0];
    nf_calib = (frame_energy_q > MIN_FLOOR_E) ? frame_energy_q : MIN_FLOOR_E;
  end

  // Next-state logic, evaluated once per completed frame
  always_comb begin
    state_d = state_q;
    onset_d = onset_q;
    hang_d  = hang_q;
    if (!enable) begin
      state_d = ST_IDLE;
      onset_d = '0;
      hang_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_CALIB;
        ST_CALIB: if (frame_strobe_q) state_d = ST_SILENCE;
        ST_SILENCE: begin
          if (frame_strobe_q && loud) begin
            if (ONSET_FRAMES == 1) begin
              state_d = ST_SPEECH;
            end else begin
              state_d = ST_ONSET;
              onset_d = ON_W'(1);
            end
          end
        end
        ST_ONSET: begin
          if (frame_strobe_q) begin
            if (!loud) begin
              state_d = ST_SILENCE;
              onset_d = '0;
            end else if (onset_q == ON_W'(ONSET_FRAMES - 1)) begin
              state_d = ST_SPEECH;
              onset_d = '0;
            end else begin
              onset_d = onset_q + ON_W'(1);
            end
          end
        end
        ST_SPEECH: begin
          if (frame_strobe_q && !loud) begin
            state_d = ST_HANG;
            hang_d  = HANG_W'(HANG_FRAMES - 1);
          end
        end
        ST_HANG: begin
          if (frame_strobe_q) begin
            if (loud) begin
              state_d = ST_SPEECH;
              hang_d  = '0;
            end else if (hang_q == '0) begin
              state_d = ST_SILENCE;
            end else begin
              hang_d = hang_q - HANG_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs: trigger on entry to SPEECH from the onset path only
  always_comb begin
    trig_d = (state_d == ST_SPEECH) && ((state_q == ST_SILENCE) || (state_q == ST_ONSET));
    nf_d   = nf_q;
    if (enable && frame_strobe_q) begin
      if (state_q == ST_CALIB) begin
        nf_d = nf_calib;
      end else if ((state_q == ST_SILENCE) && !loud) begin
        nf_d = nf_upd;
      end
    end
    // A trigger being raised or presented this cycle outranks an acknowledge
    wake_d   = enable && (trig_d || trig_q || (wake_q && !wake_ack));
    speech_d = (state_d == ST_SPEECH) || (state_d == ST_HANG);
  end

  assign vad_trigger   = trig_q;
  assign wake_req      = wake_q;
  assign speech_active = speech_q;
  assign frame_strobe  = frame_strobe_q;
  assign frame_energy  = frame_energy_q;
  assign noise_floor   = nf_q;
  assign vad_state     = state_q;

endmodule

// File: tb/tb_nanomamba_vad_wake.sv
// Scoreboard bench for nanomamba_vad_wake: a per-frame reference model queues the
// expected energy and decision, and a negedge monitor compares them.
`timescale 1ns/1ps
module tb_nanomamba_vad_wake;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample_data = '0;
  logic               wake_ack = 1'b0;
  logic               vad_trigger, wake_req, speech_active, frame_strobe;
  logic [39:0]        frame_energy, noise_floor;
  logic [2:0]         vad_state;

  nanomamba_vad_wake dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_data(sample_data), .wake_ack(wake_ack), .vad_trigger(vad_trigger),
    .wake_req(wake_req), .speech_active(speech_active), .frame_strobe(frame_strobe),
    .frame_energy(frame_energy), .noise_floor(noise_floor), .vad_state(vad_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint e;
    int     st;
    longint nf;
    bit     trig;
    bit     sp;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     n_trig = 0;
  longint m_nf = 65536;
  int     m_st = 0, m_on = 0, m_hang = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one decision per completed frame, parameters at their defaults
  task automatic model_frame(input longint e);
    exp_t x;
    bit   loud;
    bit   trig = 1'b0;
    longint d;
    loud = (e > (m_nf * 4));
    case (m_st)
      1: begin m_nf = (e > 65536) ? e : 65536; m_st = 2; end
      2: begin
        if (loud) begin m_st = 3; m_on = 1; end
        else begin
          d = e - m_nf;
          m_nf = m_nf + (d >>> 4);
          if (m_nf < 65536) m_nf = 65536;
        end
      end
      3: begin
        if (!loud) begin m_st = 2; m_on = 0; end
        else begin
          m_on++;
          if (m_on == 3) begin m_st = 4; m_on = 0; trig = 1'b1; end
        end
      end
      4: if (!loud) begin m_st = 5; m_hang = 29; end
      5: begin
        if (loud) m_st = 4;
        else if (m_hang == 0) m_st = 2;
        else m_hang--;
      end
      default: ;
    endcase
    x.e = e; x.st = m_st; x.nf = m_nf; x.trig = trig; x.sp = (m_st == 4) || (m_st == 5);
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input int amp, input bit alt);
    longint e = 0;
    int s;
    for (int i = 0; i < 160; i++) begin
      s = (alt && (i % 2 == 1)) ? -amp : amp;
      sample_data  = 16'(s);
      sample_valid = 1'b1;
      e += longint'(s) * longint'(s);
      tick();
    end
    sample_valid = 1'b0;
    model_frame(e);
  endtask

  // Monitor: energy at T+1, decision outputs and trigger pulse at T+2
  exp_t dec_exp;
  bit   dec_pending = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (vad_trigger) n_trig++;
      if (dec_pending) begin
        check("dec_state", 64'(vad_state), 64'(dec_exp.st));
        check("dec_floor", 64'(noise_floor), 64'(dec_exp.nf));
        check("dec_speech", 64'(speech_active), 64'(dec_exp.sp));
      end
      check("trigger", 64'(vad_trigger), 64'(dec_pending && dec_exp.trig));
      dec_pending = 1'b0;
      if (frame_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'(frame_strobe), 64'd0);
        end else begin
          dec_exp = exp_q.pop_front();
          check("frame_energy", 64'(frame_energy), 64'(dec_exp.e));
          dec_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_trigger", 64'(vad_trigger), 64'd0);
    check("rst_wake", 64'(wake_req), 64'd0);
    check("rst_speech", 64'(speech_active), 64'd0);
    check("rst_strobe", 64'(frame_strobe), 64'd0);
    check("rst_energy", 64'(frame_energy), 64'd0);
    check("rst_floor", 64'(noise_floor), 64'd65536);
    check("rst_state", 64'(vad_state), 64'd0);
    rst_n = 1'b1;
    tick();

    // Calibration and steady silence
    enable = 1'b1;
    m_st = 1;
    tick();
    check("calib_state", 64'(vad_state), 64'd1);
    for (int f = 0; f < 20; f++) send_frame(100, 1'b1);
    check("sil_energy", 64'(frame_energy), 64'd1600000);
    tick();
    check("sil_floor", 64'(noise_floor), 64'd1600000);
    check("sil_state", 64'(vad_state), 64'd2);
    check("sil_no_trig", 64'(n_trig), 64'd0);

    // False onset: floor frozen during loud frames, back to silence
    send_frame(1000, 1'b1);
    send_frame(1000, 1'b1);
    tick();
    check("fo_state", 64'(vad_state), 64'd3);
    check("fo_floor", 64'(noise_floor), 64'd1600000);
    send_frame(100, 1'b1);
    tick();
    check("fo_silence", 64'(vad_state), 64'd2);
    check("fo_no_trig", 64'(n_trig), 64'd0);

    // Confirmed onset
    for (int f = 0; f < 3; f++) send_frame(1000, 1'b1);
    check("on_energy", 64'(frame_energy), 64'd160000000);
    tick();
    check("on_trigger", 64'(vad_trigger), 64'd1);
    check("on_wake", 64'(wake_req), 64'd1);
    check("on_speech", 64'(speech_active), 64'd1);

    // Handshake: wake_req holds until the cycle after the ack
    repeat (50) tick();
    check("hs_hold", 64'(wake_req), 64'd1);
    wake_ack = 1'b1;
    check("hs_ack_cycle", 64'(wake_req), 64'd1);
    tick();
    wake_ack = 1'b0;
    check("hs_cleared", 64'(wake_req), 64'd0);

    // Hangover bridging a pause, then exit on the 31st quiet frame
    for (int f = 0; f < 10; f++) send_frame(100, 1'b1);
    send_frame(1000, 1'b1);
    for (int f = 0; f < 30; f++) send_frame(100, 1'b1);
    tick();
    check("hang_still_active", 64'(speech_active), 64'd1);
    send_frame(100, 1'b1);
    tick();
    check("hang_dropped", 64'(speech_active), 64'd0);
    check("hang_state", 64'(vad_state), 64'd2);
    check("hang_one_trig", 64'(n_trig), 64'd1);

    // Ack coincident with a fresh trigger: set wins
    check("co_wake_before", 64'(wake_req), 64'd0);
    for (int f = 0; f < 3; f++) send_frame(1000, 1'b1);
    tick();
    check("co_trigger", 64'(vad_trigger), 64'd1);
    wake_ack = 1'b1;
    tick();
    wake_ack = 1'b0;
    check("co_set_wins", 64'(wake_req), 64'd1);
    wake_ack = 1'b1;
    tick();
    wake_ack = 1'b0;
    check("co_cleared", 64'(wake_req), 64'd0);
    for (int f = 0; f < 31; f++) send_frame(100, 1'b1);
    tick();
    check("co_back_silence", 64'(vad_state), 64'd2);

    // Full-scale frame
    send_frame(-32768, 1'b0);
    check("fs_energy", 64'(frame_energy), 64'd171798691840);

    // Abort mid-frame, then recalibrate on a louder floor
    for (int i = 0; i < 80; i++) begin
      sample_data = 16'(200); sample_valid = 1'b1; tick();
    end
    enable = 1'b0;
    tick();
    sample_valid = 1'b0;
    m_st = 0; m_on = 0; m_hang = 0;
    check("ab_idle", 64'(vad_state), 64'd0);
    check("ab_speech", 64'(speech_active), 64'd0);
    check("ab_wake", 64'(wake_req), 64'd0);
    repeat (200) tick();
    check("ab_energy_kept", 64'(frame_energy), 64'd171798691840);
    enable = 1'b1;
    m_st = 1;
    tick();
    check("re_calib", 64'(vad_state), 64'd1);
    send_frame(200, 1'b1);
    check("re_energy", 64'(frame_energy), 64'd6400000);
    tick();
    check("re_floor", 64'(noise_floor), 64'd6400000);
    check("re_state", 64'(vad_state), 64'd2);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 50; i++) begin
      sample_data = 16'(-300); sample_valid = 1'b1; tick();
    end
    sample_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("ar_energy", 64'(frame_energy), 64'd0);
    check("ar_floor", 64'(noise_floor), 64'd65536);
    check("ar_state", 64'(vad_state), 64'd0);
    check("ar_wake", 64'(wake_req), 64'd0);
    check("total_trigs", 64'(n_trig), 64'd2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nanomamba_vad_wake.md
# nanomamba_vad_wake

Always-on energy voice-activity detector that produces the wake trigger consumed by the NanoMamba power manager. It accumulates per-frame energy from the raw 16 kHz sample stream and tracks an adaptive noise floor. It raises a one-cycle `vad_trigger` pulse plus a held `wake_req` when speech onset is confirmed. It stays in the always-on domain on ungated `clk`. Its hangover state keeps `speech_active` high across short pauses.

## Interface
- SAMPLE_W, 16, signed PCM sample width
- FRAME_LEN, 160, samples per frame (10 ms @ 16 kHz); legal range 2..1023
- ENERGY_W, 40, energy accumulator/output width; must hold FRAME_LEN·2^(2·SAMPLE_W−2)
- ONSET_FRAMES, 3, consecutive loud frames required to declare speech; ≥1
- HANG_FRAMES, 30, quiet frames tolerated before leaving speech; ≥1
- NF_SHIFT, 4, noise-floor IIR shift (α = 2^−NF_SHIFT)
- THRESH_SHIFT, 2, loud if energy > noise_floor << THRESH_SHIFT
- MIN_FLOOR, 65536, lower clamp of noise floor
- clk  in  1  always-on clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  detector enable; low = flush and hold in IDLE
- sample_valid  in  1  sample strobe; may be high every cycle, no backpressure
- sample_data  in  SAMPLE_W  signed PCM sample
- wake_ack  in  1  power manager acknowledge (status_busy)
- vad_trigger  out  1  one-cycle pulse on confirmed onset
- wake_req  out  1  level wake request, held until acknowledged
- speech_active  out  1  high in SPEECH or HANGOVER
- frame_strobe  out  1  one-cycle pulse, frame_energy newly valid
- frame_energy  out  ENERGY_W  energy of last completed frame
- noise_floor  out  ENERGY_W  current noise floor estimate
- vad_state  out  3  FSM state encoding

## Operation
- Energy: each accepted sample adds sample_data² (unsigned, 2·SAMPLE_W−1 bits; −32768² = 2^30) to acc. The FRAME_LEN-th sample completes the frame. No saturation is needed given the width rule.
- Compare: loud = frame_energy > (noise_floor << THRESH_SHIFT). Evaluate at ENERGY_W+THRESH_SHIFT bits, no overflow.
- Noise floor update: nf + ((E − nf) >>> NF_SHIFT), computed at ENERGY_W+1 bits signed, arithmetic shift (floor toward −∞). The result is clamped to ≥ MIN_FLOOR.
- States, each with its per-frame decision:
  - IDLE(0): entered while enable=0. acc, sample count, onset/hang counters, wake_req and speech_active are cleared. noise_floor is retained. enable=1 moves to CALIB.
  - CALIB(1): first complete frame loads noise_floor = max(E, MIN_FLOOR). Then → SILENCE. No trigger.
  - SILENCE(2): quiet frame updates the noise floor. A loud frame → ONSET with onset_cnt=1, or → SPEECH with trigger if ONSET_FRAMES=1.
  - ONSET(3): a loud frame increments onset_cnt; reaching ONSET_FRAMES → SPEECH with trigger. A quiet frame → SILENCE with onset_cnt=0 and no floor update.
  - SPEECH(4): a loud frame stays. A quiet frame → HANGOVER with hang_cnt=HANG_FRAMES−1.
  - HANGOVER(5): a loud frame → SPEECH with no new trigger. A quiet frame with hang_cnt=0 → SILENCE, otherwise hang_cnt decrements. speech_active drops on the (HANG_FRAMES+1)-th consecutive quiet frame.
- Noise floor is frozen outside SILENCE/CALIB.
- Trigger: vad_trigger=1 for exactly one cycle, and wake_req is set.
- wake_req clears the cycle after wake_ack is sampled high. If trigger and ack coincide, set wins.
- enable deassert mid-frame discards the partial frame. The next frame starts with the first sample after re-enable and recalibrates.

## Timing
- Reset values: vad_trigger 0, wake_req 0, speech_active 0, frame_strobe 0, frame_energy 0, noise_floor MIN_FLOOR, vad_state IDLE.
- Cycle T, in which the last sample is accepted: frame_energy ← acc+sq, and acc and count clear.
- T+1: frame_strobe=1 and frame_energy valid. The FSM and noise floor are registered at the end of T+1.
- T+2: new vad_state, noise_floor, speech_active and vad_trigger are visible.
- A sample at T+1 accumulates into the next frame, so there are no bubbles at back-to-back sample_valid.
- wake_ack high at cycle A → wake_req low at A+1.
- enable low at cycle D → vad_state=IDLE at D+1. A sample accepted in cycle D is discarded.
- rst_n asserted mid-frame: all state returns to reset values asynchronously.

## Test plan
- Calibration/silence:
  - Stimulus: enable, then 20 frames of alternating ±100.
  - Required: frame_energy=1,600,000 each frame, noise_floor=1,600,000 after the first frame, vad_trigger never high, vad_state=SILENCE.
- Onset:
  - Stimulus: after the silence above, 3 frames of ±1000.
  - Required: energy=160,000,000 > 6,400,000; vad_trigger is a single pulse at T+2 of the third loud frame; wake_req=1; speech_active=1.
- False onset:
  - Stimulus: 2 loud frames, then 1 quiet frame.
  - Required: ONSET→SILENCE, no trigger, noise_floor unchanged across the loud frames.
- Handshake:
  - Stimulus: wake_ack held low for 50 cycles after the trigger, then a 1-cycle pulse.
  - Required: wake_req stays high until the cycle after the ack, then 0. Also with ack coincident with a new trigger: wake_req stays 1.
- Hangover:
  - Stimulus: in SPEECH, 10 quiet frames, 1 loud frame, then 31 quiet frames.
  - Required: no second trigger; speech_active falls at T+2 of the 31st quiet frame.
- Full scale + abort:
  - Stimulus: a full frame of −32768.
  - Required: frame_energy=171,798,691,840 with no wrap.
  - Stimulus: then enable low at sample 80 of the next frame.
  - Required: IDLE next cycle, no frame_strobe, and re-enable recalibrates.
